// File: rtl/hidden_result_collector.sv
// Sequences the two hidden-layer neuron groups, captures their results and
// streams the 20 captured neuron bytes to the output-layer feeder.
module hidden_result_collector #(
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         go,
    input  logic [0:159] hidden_out,
    input  logic         ready1,
    input  logic         ready2,
    output logic         start1,
    output logic         start2,
    output logic         received,
    output logic [0:159] result,
    output logic [7:0]   byte_out,
    output logic         byte_valid,
    input  logic         byte_ready,
    output logic         busy,
    output logic         done,
    output logic         timeout_err
);

    typedef enum logic [2:0] {
        IDLE, RUN1, WAIT1, CAP1, RUN2, WAIT2, CAP2, STREAM
    } state_t;

    state_t         state, state_d;
    logic [15:0]    cnt, cnt_d;
    logic [4:0]     idx, idx_d;
    logic [0:159]   result_d;
    logic [7:0]     byte_out_d;
    logic           timeout_err_d;
    logic           accept, expired, last;

    assign accept  = byte_valid && byte_ready;
    assign expired = (cnt == 16'(TIMEOUT - 1));
    assign last    = (idx == 5'd19);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (go) state_d = RUN1;
            RUN1:    state_d = WAIT1;
            WAIT1: begin
                if (ready1)       state_d = CAP1;
                else if (expired) state_d = IDLE;
            end
            CAP1:    state_d = RUN2;
            RUN2:    state_d = WAIT2;
            WAIT2: begin
                if (ready2)       state_d = CAP2;
                else if (expired) state_d = IDLE;
            end
            CAP2:    state_d = STREAM;
            STREAM:  if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the upcoming state so that every output is
    // a flop yet still lines up with the state it belongs to.
    always_comb begin
        cnt_d         = '0;
        idx_d         = idx;
        result_d      = result;
        timeout_err_d = timeout_err;
        byte_out_d    = '0;
        if (state == WAIT1 || state == WAIT2) cnt_d = cnt + 16'd1;
        if (state == IDLE && go) timeout_err_d = 1'b0;
        if ((state == WAIT1 && !ready1 && expired) ||
            (state == WAIT2 && !ready2 && expired)) timeout_err_d = 1'b1;
        if (state == WAIT1 && ready1) result_d[0:79]   = hidden_out[0:79];
        if (state == WAIT2 && ready2) result_d[80:159] = hidden_out[80:159];
        if (state == CAP2) begin
            idx_d = '0;
        end else if (state == STREAM && accept) begin
            idx_d = last ? 5'd0 : idx + 5'd1;
        end
        if (state_d == STREAM) byte_out_d = result_d[{idx_d, 3'b000} +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= '0;
            idx         <= '0;
            result      <= '0;
            byte_out    <= '0;
            byte_valid  <= 1'b0;
            start1      <= 1'b0;
            start2      <= 1'b0;
            received    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            cnt         <= cnt_d;
            idx         <= idx_d;
            result      <= result_d;
            byte_out    <= byte_out_d;
            byte_valid  <= (state_d == STREAM);
            start1      <= (state_d == RUN1);
            start2      <= (state_d == RUN2);
            received    <= (state_d == CAP1) || (state_d == CAP2);
            busy        <= (state_d != IDLE);
            done        <= (state == STREAM) && (state_d == IDLE);
            timeout_err <= timeout_err_d;
        end
    end

endmodule

// File: tb/tb_hidden_result_collector.sv
// Bench for hidden_result_collector: table of run scenarios driven through a
// cycle-level responder, with a byte scoreboard checked by a stream monitor.
module tb_hidden_result_collector;

    localparam int unsigned TO = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         go = 1'b0;
    logic         ready1 = 1'b0;
    logic         ready2 = 1'b0;
    logic         byte_ready = 1'b0;
    logic [0:159] hidden_out = '0;
    logic [0:159] result;
    logic         start1, start2, received, byte_valid, busy, done, timeout_err;
    logic [7:0]   byte_out;

    hidden_result_collector #(.TIMEOUT(TO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (go),
        .hidden_out  (hidden_out),
        .ready1      (ready1),
        .ready2      (ready2),
        .start1      (start1),
        .start2      (start2),
        .received    (received),
        .result      (result),
        .byte_out    (byte_out),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         d1;          // WAIT1 cycle on which ready1 is seen (0 = never)
        int         d2;          // WAIT2 cycle on which ready2 is seen
        logic [7:0] base;        // first neuron byte value
        bit         bp_toggle;   // byte_ready toggles 1010...
        bit         early_r2;    // ready2 raised during WAIT1
        bit         go_mid;      // go pulsed in WAIT2, in STREAM and on last accept
        int         rst_at;      // reset when idx reaches this value (0 = none)
        bit         exp_timeout;
        int         exp_latency; // go-to-done cycles, -1 when not checked
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] sb[$];

    int n_s1, n_s2, n_rcv, n_done, n_bytes;
    int t_s1, t_s2, t_r1, t_r2, t_fv, t_done;
    bit fv_seen;
    bit hold_pending;
    logic [7:0] hold_val;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [0:159] act, input logic [0:159] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        logic [7:0] e;
        if (hold_pending) begin
            check("valid_hold", int'(byte_valid), 1);
            check("byte_hold", int'(byte_out), int'(hold_val));
        end
        if (start1) begin n_s1++; t_s1 = cyc; end
        if (start2) begin n_s2++; t_s2 = cyc; end
        if (received) begin
            n_rcv++;
            if (n_rcv == 1) t_r1 = cyc;
            else t_r2 = cyc;
        end
        if (byte_valid && !fv_seen) begin fv_seen = 1'b1; t_fv = cyc; end
        hold_pending = byte_valid && !byte_ready;
        hold_val = byte_out;
        if (byte_valid && byte_ready) begin
            n_bytes++;
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got byte %0h with no expected entry", byte_out);
            end else begin
                e = sb.pop_front();
                check("stream_byte", int'(byte_out), int'(e));
            end
        end
        if (done) begin n_done++; t_done = cyc; end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_start1"}, int'(start1), 0);
        check({tag, "_start2"}, int'(start2), 0);
        check({tag, "_received"}, int'(received), 0);
        check({tag, "_byte_valid"}, int'(byte_valid), 0);
        check({tag, "_byte_out"}, int'(byte_out), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_timeout_err"}, int'(timeout_err), 0);
        check_vec({tag, "_result"}, result, '0);
    endtask

    task automatic run_case(input int id, input vec_t v);
        logic [0:159] exp_res, g1, g2;
        int g, phase, w, vc, acc, t_err;
        bit fin, br_t;
        exp_res = '0;
        g1 = '0;
        g2 = '0;
        for (int i = 0; i < 20; i++) begin
            exp_res[8*i +: 8] = v.base + 8'(i);
            g1[8*i +: 8] = (i < 10)  ? v.base + 8'(i) : 8'hA5 ^ 8'(i);
            g2[8*i +: 8] = (i >= 10) ? v.base + 8'(i) : 8'h5A ^ 8'(i);
            if (!v.exp_timeout) sb.push_back(v.base + 8'(i));
        end
        n_s1 = 0; n_s2 = 0; n_rcv = 0; n_done = 0; n_bytes = 0;
        t_s1 = -1; t_s2 = -1; t_r1 = -1; t_r2 = -1; t_fv = -1; t_done = -1;
        fv_seen = 1'b0;
        hold_pending = 1'b0;

        hidden_out = g1;
        go = 1'b1;
        g = cyc;
        step();
        go = 1'b0;
        check($sformatf("c%0d_start1_after_go", id), int'(start1), 1);
        check($sformatf("c%0d_busy_after_go", id), int'(busy), 1);
        check($sformatf("c%0d_err_cleared", id), int'(timeout_err), 0);
        step();

        phase = 1; w = 0; vc = 0; acc = 0; fin = 1'b0; br_t = 1'b0; t_err = -1;
        for (int c = 0; c < 400 && !fin; c++) begin
            go = 1'b0;
            br_t = !br_t;
            byte_ready = v.bp_toggle ? br_t : 1'b1;
            case (phase)
                1: begin
                    if (received) begin
                        ready1 = 1'b0;
                        phase = 2;
                        hidden_out = g2;
                    end else if (v.exp_timeout && timeout_err) begin
                        t_err = cyc;
                        fin = 1'b1;
                    end else begin
                        w++;
                        if (v.d1 != 0 && w == v.d1) begin
                            ready1 = 1'b1;
                            ready2 = 1'b0;
                        end else if (v.early_r2 && v.d1 != 0 && w < v.d1) begin
                            ready2 = 1'b1;
                        end
                    end
                end
                2: if (start2) begin phase = 3; w = 0; end
                3: begin
                    if (received) begin
                        ready2 = 1'b0;
                        phase = 4;
                    end else begin
                        w++;
                        if (w == v.d2) ready2 = 1'b1;
                        if (v.go_mid && w == 1) go = 1'b1;
                    end
                end
                default: begin
                    if (v.rst_at != 0 && acc == v.rst_at) begin
                        rst_n = 1'b0;
                        step();
                        check_all_zero($sformatf("c%0d_midrst", id));
                        rst_n = 1'b1;
                        sb.delete();
                        hold_pending = 1'b0;
                        fin = 1'b1;
                    end else begin
                        if (byte_valid) vc++;
                        if (done) begin
                            fin = 1'b1;
                        end else if (byte_valid && byte_ready) begin
                            acc++;
                            if (v.go_mid && (vc == 3 || acc == 20)) go = 1'b1;
                        end
                    end
                end
            endcase
            step();
        end
        if (!fin) begin
            n_checks++;
            n_errors++;
            $display("FAIL c%0d_run_bound: got no completion expected completion within 400 cycles", id);
        end
        go = 1'b0;
        ready1 = 1'b0;
        ready2 = 1'b0;
        repeat (3) step();

        if (v.exp_timeout) begin
            check($sformatf("c%0d_err_cycle", id), t_err, t_s1 + int'(TO) + 1);
            check($sformatf("c%0d_err_sticky", id), int'(timeout_err), 1);
            check($sformatf("c%0d_busy_after_err", id), int'(busy), 0);
            check($sformatf("c%0d_no_start2", id), n_s2, 0);
            check($sformatf("c%0d_no_received", id), n_rcv, 0);
        end else if (v.rst_at != 0) begin
            check($sformatf("c%0d_no_done", id), n_done, 0);
            check($sformatf("c%0d_start1_once", id), n_s1, 1);
            check($sformatf("c%0d_idle_after_rst", id), int'(busy), 0);
        end else begin
            check($sformatf("c%0d_start1_once", id), n_s1, 1);
            check($sformatf("c%0d_start2_once", id), n_s2, 1);
            check($sformatf("c%0d_received_twice", id), n_rcv, 2);
            check($sformatf("c%0d_done_once", id), n_done, 1);
            check($sformatf("c%0d_bytes", id), n_bytes, 20);
            check($sformatf("c%0d_sb_left", id), sb.size(), 0);
            check($sformatf("c%0d_timeout_err", id), int'(timeout_err), 0);
            check($sformatf("c%0d_busy_end", id), int'(busy), 0);
            check($sformatf("c%0d_t_received1", id), t_r1, t_s1 + v.d1 + 1);
            check($sformatf("c%0d_t_start2", id), t_s2, t_r1 + 1);
            check($sformatf("c%0d_t_received2", id), t_r2, t_s2 + v.d2 + 1);
            check($sformatf("c%0d_t_first_valid", id), t_fv, t_r2 + 1);
            if (v.exp_latency >= 0)
                check($sformatf("c%0d_latency", id), t_done - g, v.exp_latency);
            check_vec($sformatf("c%0d_result", id), result, exp_res);
        end
        sb.delete();
    endtask

    initial begin
        vec_t vecs[8];
        // d1, d2, base, bp_toggle, early_r2, go_mid, rst_at, exp_timeout, exp_latency
        vecs[0] = '{3, 3, 8'h01, 1'b0, 1'b0, 1'b0, 0, 1'b0, 31};
        vecs[1] = '{1, 1, 8'h40, 1'b0, 1'b0, 1'b0, 0, 1'b0, 27};
        vecs[2] = '{3, 5, 8'h80, 1'b1, 1'b0, 1'b0, 0, 1'b0, -1};
        vecs[3] = '{8, 2, 8'hC0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 35};
        vecs[4] = '{2, 8, 8'h10, 1'b0, 1'b0, 1'b1, 0, 1'b0, 35};
        vecs[5] = '{0, 0, 8'h20, 1'b0, 1'b0, 1'b0, 0, 1'b1, -1};
        vecs[6] = '{2, 2, 8'h30, 1'b0, 1'b0, 1'b0, 7, 1'b0, -1};
        vecs[7] = '{4, 1, 8'h55, 1'b0, 1'b0, 1'b0, 0, 1'b0, 30};

        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        check_all_zero("reset");
        step();

        for (int k = 0; k < 8; k++) run_case(k, vecs[k]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hidden_result_collector.md
# hidden_result_collector

Sequencer and consumer on the far side of the hidden layer's start/ready/received handshake. It launches the two ten-neuron groups one after the other, captures each 80-bit group result when its ready rises, and acknowledges with received. It then streams the 20 captured neuron bytes, one per handshake, to the output-layer feeder. A watchdog aborts the run if a group never reports ready.

## Interface
- TIMEOUT, 4096: cycles allowed in each wait state before abort (legal range 2..65535).
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  reset, synchronous and active-low.
- go  in  1  one-cycle request to run one inference; honoured only in IDLE.
- hidden_out  in  [0:159]  hidden-layer result; byte i = bits [8i:8i+7], bit 8i is the MSB.
- ready1, ready2  in  1  group-done levels; held until received is seen.
- start1, start2  out  1  one-cycle group launch pulses.
- received  out  1  one-cycle acknowledge after each capture.
- result  out  [0:159]  captured neuron bytes; held until the next capture.
- byte_out  out  8  current stream byte.
- byte_valid  out  1  byte_out is valid.
- byte_ready  in  1  downstream accepts when byte_valid and byte_ready are both high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last byte is accepted.
- timeout_err  out  1  sticky abort flag; cleared by the next accepted go or by reset.

## Operation
- All outputs are registered. Reset value of every output is 0. result is also cleared to 0 on reset.
- FSM states: IDLE, RUN1, WAIT1, CAP1, RUN2, WAIT2, CAP2, STREAM.
- IDLE: on go, clear timeout_err and go to RUN1.
- RUN1: start1=1 for this state only, then go to WAIT1.
- WAIT1: the watchdog counter increments each cycle.
  - If ready1=1, go to CAP1.
  - Else, if the counter reaches TIMEOUT-1, set timeout_err=1 and go to IDLE.
- CAP1: result[0:79] <= hidden_out[0:79]; received=1; counter cleared; go to RUN2.
- RUN2: start2=1 for this state only, then go to WAIT2.
- WAIT2: same as WAIT1, using ready2.
- CAP2: result[80:159] <= hidden_out[80:159]; received=1; byte index cleared to 0; go to STREAM.
- STREAM:
  - byte_valid=1 and byte_out=result[8*idx +: 8], with idx running 0..19.
  - On each accepted transfer, idx increments.
  - On acceptance at idx=19, byte_valid drops, done pulses, and the FSM returns to IDLE.
- The watchdog counter is 16 bits wide and is cleared on entry to WAIT1 and WAIT2. Byte index is 5 bits.
- Boundary rules:
  - go while busy: ignored, no effect.
  - ready2 during WAIT1, or ready1 during WAIT2: ignored.
  - ready and timeout on the same cycle: ready wins, no error.
  - byte_ready held low: byte_out and byte_valid stay stable indefinitely; there is no timeout in STREAM.
  - rst_n low in any state: the next edge returns the FSM to IDLE with all outputs 0. No partial stream resumes.
  - go on the same cycle as done: ignored, because the FSM is not yet in IDLE.

## Timing
- go sampled high at edge 0: start1=1 during cycle 1.
- ready1 sampled high at edge k: received=1 and result[0:79] updated during cycle k+1; start1... start2=1 during cycle k+2.
- Same latency applies to group 2. The first byte_valid=1 appears in the cycle after the CAP2 cycle.
- Stream throughput: one byte per cycle when byte_ready is held high.
- Best case, ready arriving one cycle after each start: go to done is 27 cycles.
- Timeout fires at the TIMEOUT-th WAIT cycle without ready. timeout_err is visible the following cycle, with busy=0.

## Test plan
- Nominal run:
  - Stimulus: go; ready1 3 cycles after start1 with hidden_out[0:79]=0x01..0x0A; ready2 3 cycles after start2 with [80:159]=0x0B..0x14; byte_ready=1.
  - Response: bytes 0x01..0x14 in order, received pulsed exactly twice, one done pulse, timeout_err=0.
- Backpressure:
  - Stimulus: toggle byte_ready 1010… during STREAM.
  - Response: 20 bytes, no duplicates or drops, byte_out stable while not accepted.
- Timeout:
  - Stimulus: TIMEOUT=8, ready1 never rises.
  - Response: timeout_err=1 after 8 WAIT1 cycles, FSM in IDLE, start2 never pulses. A new go clears the flag.
- Race:
  - Stimulus: ready2 asserted during WAIT1; then ready1 on exactly cycle TIMEOUT-1.
  - Response: ready2 ignored, no error, run completes.
- Reset mid-stream:
  - Stimulus: rst_n=0 for 1 cycle at idx=7.
  - Response: all outputs 0 and result=0 next cycle. A fresh go restarts from RUN1.
- go while busy:
  - Stimulus: pulse go during WAIT2 and during STREAM.
  - Response: no extra start pulses; sequence unaffected.
